brnch_fetch_redirect_seq: RTL
=============================

// Module: brnch_fetch_redirect_seq
// PURPOSE
// - IF-stage PC sequencer; consumer of the ID-stage 1-bit dynamic branch handler's br_prediction/flush/branch_hazard_stall.
// - Acts on predictions in IF, records the alternate-path PC as a branch moves IF->ID, and restores that PC on mispredict.
// - Supplies the predictor index (branch_addr_lw_5b), IF/ID write/flush controls and saturating branch statistics.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on reset
// - CNT_W     16             width of the saturating statistics counters
// PORTS
// - clk                  in   1      clock
// - rst_n                in   1      synchronous, active-low reset
// - load_use_stall       in   1      load-use hazard from the main hazard unit; freezes PC and IF/ID
// - branch_hazard_stall  in   1      branch operand hazard from the ID branch handler; freezes PC and IF/ID
// - brnch_detect_IF      in   1      instruction in IF is a beq (opcode 6'b000100)
// - imm_IF               in   16     beq offset field of the instruction in IF
// - br_prediction        in   1      predict-taken for the beq in IF; arrives already gated by branch_hazard_stall
// - flush                in   1      mispredict for the beq in ID; arrives already gated by branch_hazard_stall
// - pc_IF                out  32     current fetch address (registered)
// - branch_addr_lw_5b    out  5      pc_IF[6:2], predictor table index
// - pc_write_en          out  1      PC advances this cycle
// - IFID_write_en        out  1      IF/ID register captures this cycle
// - IFID_flush           out  1      IF/ID register loads a bubble this cycle
// - redirect_active      out  1      FSM is in S_REDIR
// - brnch_resolved_cnt   out  CNT_W  count of beqs that resolved in ID
// - mispred_cnt          out  CNT_W  count of flushes
// BEHAVIOUR
// - Arithmetic (all 32-bit; carry out of bit 31 discarded, so PC wraps):
//   - seq  = pc_IF + 4
//   - tgt  = seq + ({{14{imm_IF[15]}}, imm_IF, 2'b00})
// - stall = load_use_stall | branch_hazard_stall.
// - Next-PC priority: flush > stall > (brnch_detect_IF & br_prediction) > seq.
//   - flush:       pc_IF <= alt_ID.
//   - stall:       pc_IF held.
//   - predicted:   pc_IF <= tgt.
//   - otherwise:   pc_IF <= seq.
// - Control outputs:
//   - pc_write_en   = flush | !stall.
//   - IFID_write_en = !stall | flush.
//   - IFID_flush    = flush. It is combinational in the same cycle, squashing the wrong-path instruction in IF.
// - Recovery pipeline (alt_ID[31:0], br_valid_ID) loads when IFID_write_en & !flush:
//   - br_valid_ID <= brnch_detect_IF.
//   - alt_ID      <= br_prediction ? seq : tgt.
//   - On flush: br_valid_ID <= 0, alt_ID held.
//   - On stall: both held.
// - flush while br_valid_ID==0 is a protocol error. The redirect still goes to alt_ID; a bench assertion flags it.
// - FSM (2-bit state register):
//   - S_RUN:   flush -> S_REDIR; stall -> S_STALL; else stay.
//   - S_STALL: flush -> S_REDIR; !stall -> S_RUN; else stay.
//   - S_REDIR: lasts exactly 1 cycle (bubble in ID). Then stall -> S_STALL, else S_RUN.
//   - flush in S_REDIR: ignored, because br_valid_ID==0 there.
//   - redirect_active = (state==S_REDIR).
// - Counters, saturating at all-ones with no wrap:
//   - brnch_resolved_cnt: +1 on each cycle with br_valid_ID & !branch_hazard_stall.
//   - mispred_cnt: +1 on each flush.
// - Reset state: pc_IF=RESET_PC, state=S_RUN, alt_ID=0, br_valid_ID=0, counters=0.
//   - Outputs in reset: pc_write_en=1, IFID_write_en=1, IFID_flush=0, redirect_active=0.
//   - Reset asserted mid-redirect or mid-stall overrides everything on the next edge.
// - Latency:
//   - A prediction applies on the edge after the cycle it is sampled.
//   - Mispredict recovery is 1 bubble: branch in ID at cycle t, correct-path fetch at t+1.
// - Simultaneous stall & flush: the flush is taken and the stall is ignored for that cycle.
// TESTING
// - Reset: rst_n=0 for 2 cycles -> pc_IF=0, counters=0, IFID_flush=0; after release pc_IF steps 0,4,8.
// - Predicted taken: pc_IF=0x40, beq with imm=0x0003, br_prediction=1 -> next pc_IF=0x50, alt_ID=0x44; no flush next cycle -> pc_IF=0x54.
// - Mispredict, predicted not-taken: pc_IF=0x40, imm=0xFFFE, pred=0 -> pc_IF=0x44, alt_ID=0x3C.
//   Then flush=1 -> IFID_flush=1, pc_IF=0x3C, state S_REDIR for 1 cycle, mispred_cnt=1.
// - Stall: branch_hazard_stall=1 for 2 cycles with the beq in ID -> pc_IF, alt_ID held and write enables 0.
//   Then flush=1 -> redirect to alt_ID.
// - Priority: load_use_stall=1 together with flush=1 -> pc_IF<=alt_ID and IFID_flush=1.
//   Also pc_IF=0xFFFF_FFFC sequential -> 0x0000_0000 (wrap).
// - Saturation: force mispred_cnt=16'hFFFE, 3 flushes -> holds at 16'hFFFF.
//   Also assert on any flush with br_valid_ID==0.

Source files
------------

// File: rtl/brnch_fetch_redirect_seq_if.sv
// IF-stage fetch/redirect bundle between the ID branch handler and the PC sequencer.
// The master side drives the hazard and prediction inputs; the slave side is the sequencer.
interface brnch_fetch_redirect_seq_if #(
  parameter int CNT_W = 16
);
  logic             load_use_stall;
  logic             branch_hazard_stall;
  logic             brnch_detect_IF;
  logic [15:0]      imm_IF;
  logic             br_prediction;
  logic             flush;
  logic [31:0]      pc_IF;
  logic [4:0]       branch_addr_lw_5b;
  logic             pc_write_en;
  logic             IFID_write_en;
  logic             IFID_flush;
  logic             redirect_active;
  logic [CNT_W-1:0] brnch_resolved_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output load_use_stall, branch_hazard_stall, brnch_detect_IF, imm_IF,
           br_prediction, flush,
    input  pc_IF, branch_addr_lw_5b, pc_write_en, IFID_write_en, IFID_flush,
           redirect_active, brnch_resolved_cnt, mispred_cnt
  );

  modport slave (
    input  load_use_stall, branch_hazard_stall, brnch_detect_IF, imm_IF,
           br_prediction, flush,
    output pc_IF, branch_addr_lw_5b, pc_write_en, IFID_write_en, IFID_flush,
           redirect_active, brnch_resolved_cnt, mispred_cnt
  );
endinterface

// File: rtl/brnch_fetch_redirect_seq.sv
// IF-stage PC sequencer: follows beq predictions, remembers the alternate path as the
// branch moves to ID, and restores it on mispredict. Also keeps saturating branch stats.
//
// state   | meaning
// S_RUN   | normal fetch
// S_STALL | PC and IF/ID frozen by a load-use or branch operand hazard
// S_REDIR | one-cycle bubble in ID after a mispredict redirect
module brnch_fetch_redirect_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  brnch_fetch_redirect_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      alt_id_q, alt_id_d;
  logic             br_valid_id_q, br_valid_id_d;
  logic [CNT_W-1:0] resolved_cnt_q, resolved_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic        stall;
  logic        ifid_we;
  logic [31:0] seq_pc;
  logic [31:0] tgt_pc;

  always_comb begin
    stall   = bus.load_use_stall | bus.branch_hazard_stall;
    ifid_we = !stall | bus.flush;
    seq_pc  = pc_q + 32'd4;
    tgt_pc  = seq_pc + {{14{bus.imm_IF[15]}}, bus.imm_IF, 2'b00};

    // A flush overrides any stall in the same cycle.
    pc_d = pc_q;
    if (bus.flush)
      pc_d = alt_id_q;
    else if (!stall)
      pc_d = (bus.brnch_detect_IF && bus.br_prediction) ? tgt_pc : seq_pc;

    alt_id_d      = alt_id_q;
    br_valid_id_d = br_valid_id_q;
    if (bus.flush) begin
      br_valid_id_d = 1'b0;
    end else if (ifid_we) begin
      br_valid_id_d = bus.brnch_detect_IF;
      alt_id_d      = bus.br_prediction ? seq_pc : tgt_pc;
    end

    resolved_cnt_d = resolved_cnt_q;
    if (br_valid_id_q && !bus.branch_hazard_stall && (resolved_cnt_q != {CNT_W{1'b1}}))
      resolved_cnt_d = resolved_cnt_q + CNT_W'(1);

    mispred_cnt_d = mispred_cnt_q;
    if (bus.flush && (mispred_cnt_q != {CNT_W{1'b1}}))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);

    // S_REDIR never looks at flush: no valid branch can be in ID during the bubble.
    state_d = state_q;
    case (state_q)
      S_RUN:   if (bus.flush) state_d = S_REDIR; else if (stall) state_d = S_STALL;
      S_STALL: if (bus.flush) state_d = S_REDIR; else if (!stall) state_d = S_RUN;
      S_REDIR: state_d = stall ? S_STALL : S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      pc_q           <= RESET_PC;
      alt_id_q       <= 32'd0;
      br_valid_id_q  <= 1'b0;
      resolved_cnt_q <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      alt_id_q       <= alt_id_d;
      br_valid_id_q  <= br_valid_id_d;
      resolved_cnt_q <= resolved_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign bus.pc_IF              = pc_q;
  assign bus.branch_addr_lw_5b  = pc_q[6:2];
  assign bus.pc_write_en        = bus.flush | !stall;
  assign bus.IFID_write_en      = ifid_we;
  assign bus.IFID_flush         = bus.flush;
  assign bus.redirect_active    = (state_q == S_REDIR);
  assign bus.brnch_resolved_cnt = resolved_cnt_q;
  assign bus.mispred_cnt        = mispred_cnt_q;

endmodule
